// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one adder, WIDTH accumulate cycles plus a sign-fixup cycle.
// Unsigned or two's-complement per operation, with valid/ready handshakes on both sides.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_z;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_sign;

    logic               w_accept;
    logic               w_handoff;
    logic               w_calc_end;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_sign;

    assign w_accept   = in_valid && in_ready;
    assign w_handoff  = out_valid && out_ready;
    assign w_calc_end = (r_cnt == CW'(WIDTH));

    // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
    always_comb begin
        w_mag_a = (signed_mode && a[WIDTH-1]) ? ('0 - a) : a;
        w_mag_b = (signed_mode && b[WIDTH-1]) ? ('0 - b) : b;
        w_sign  = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]) && (|a) && (|b);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_next = S_CALC;
            S_CALC:  if (w_calc_end) w_next = S_DONE;
            S_DONE:  if (w_handoff)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
        z         = r_z;
    end

    // WIDTH accumulate cycles, then one extra CALC cycle applies the sign into z.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_z      <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= w_sign;
        end else if (r_state == S_CALC) begin
            if (w_calc_end) begin
                r_z <= r_sign ? ('0 - r_acc) : r_acc;
            end else begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8, plus an exhaustive WIDTH=4 sweep.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid8 = 1'b0, in_ready8, sm8 = 1'b0, out_valid8, out_ready8 = 1'b0, busy8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] z8;

    logic        in_valid4 = 1'b0, in_ready4, sm4 = 1'b0, out_valid4, out_ready4 = 1'b0, busy4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  z4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
        .out_ready(out_ready8), .z(z8), .busy(busy8)
    );

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4),
        .out_ready(out_ready4), .z(z4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tsm);
        a8 = ta; b8 = tb; sm8 = tsm; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
    endtask

    task automatic wait_valid8(output int n, output bit timed_out);
        n = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid8) begin
                timed_out = 1'b0;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic handshake8();
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        n_checks++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready8); end
        n_checks++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid8); end
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        n_checks++; if (z8 !== 16'h0000) begin n_fail++; $display("FAIL reset_z got=%h exp=0000", z8); end
    endtask

    task automatic test_unsigned();
        int n; bit to;
        start_op8(8'd255, 8'd255, 1'b0);
        n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL u_busy_calc got=%b exp=1", busy8); end
        wait_valid8(n, to);
        n_checks++; if (to || n != 9) begin n_fail++; $display("FAIL u_latency got=%0d timeout=%0b exp=9", n, to); end
        n_checks++; if (z8 !== 16'hFE01) begin n_fail++; $display("FAIL u_255x255 got=%h exp=fe01", z8); end
        handshake8();
        start_op8(8'd0, 8'd200, 1'b0);
        wait_valid8(n, to);
        n_checks++; if (to || z8 !== 16'h0000) begin n_fail++; $display("FAIL u_0x200 got=%h timeout=%0b exp=0000", z8, to); end
        handshake8();
    endtask

    task automatic test_signed();
        logic [7:0]  va [6] = '{8'h80, 8'hFF, 8'h80, 8'h80, 8'h00, 8'h05};
        logic [7:0]  vb [6] = '{8'h80, 8'h7F, 8'h01, 8'h01, 8'hFB, 8'hFD};
        logic        vs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] vz [6] = '{16'h4000, 16'hFF81, 16'hFF80, 16'h0080, 16'h0000, 16'hFFF1};
        int n; bit to;
        for (int i = 0; i < 6; i++) begin
            start_op8(va[i], vb[i], vs[i]);
            wait_valid8(n, to);
            n_checks++;
            if (to || z8 !== vz[i]) begin
                n_fail++;
                $display("FAIL s_vec%0d a=%h b=%h sm=%0b got=%h timeout=%0b exp=%h", i, va[i], vb[i], vs[i], z8, to, vz[i]);
            end
            handshake8();
        end
    endtask

    task automatic test_backpressure();
        int n; bit to;
        start_op8(8'd3, 8'd5, 1'b0);
        wait_valid8(n, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL bp_valid got=timeout exp=out_valid"); end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (out_valid8 !== 1'b1 || z8 !== 16'd15 || in_ready8 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d got v=%b z=%h rdy=%b exp v=1 z=000f rdy=0", i, out_valid8, z8, in_ready8);
            end
        end
        handshake8();
        n_checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got v=%b rdy=%b busy=%b exp v=0 rdy=1 busy=0", out_valid8, in_ready8, busy8);
        end
        n_checks++; if (z8 !== 16'd15) begin n_fail++; $display("FAIL bp_z_kept got=%h exp=000f", z8); end
    endtask

    task automatic test_back_to_back();
        int n; bit to;
        start_op8(8'd7, 8'd9, 1'b0);
        a8 = 8'd100; b8 = 8'd100; sm8 = 1'b1; in_valid8 = 1'b1;
        wait_valid8(n, to);
        n_checks++; if (to || n != 9 || z8 !== 16'd63) begin n_fail++; $display("FAIL b2b_first got=%h lat=%0d timeout=%0b exp=003f lat=9", z8, n, to); end
        n_checks++; if (in_ready8 !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_done got=%b exp=0", in_ready8); end
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        n_checks++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_rdy got=%b exp=1", in_ready8); end
        tick();
        in_valid8 = 1'b0;
        n_checks++; if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept busy=%b rdy=%b exp busy=1 rdy=0", busy8, in_ready8); end
        wait_valid8(n, to);
        // 100*100 signed (both positive) = 10000
        n_checks++; if (to || z8 !== 16'h2710) begin n_fail++; $display("FAIL b2b_second got=%h timeout=%0b exp=2710", z8, to); end
        handshake8();
    endtask

    task automatic test_reset_mid();
        int n; bit to; bit seen;
        start_op8(8'd50, 8'd60, 1'b0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || z8 !== 16'h0000) begin
            n_fail++;
            $display("FAIL rmid_state got rdy=%b v=%b busy=%b z=%h exp rdy=1 v=0 busy=0 z=0000", in_ready8, out_valid8, busy8, z8);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid8) seen = 1'b1;
            tick();
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL rmid_no_valid got=1 exp=0"); end
        start_op8(8'd12, 8'd13, 1'b0);
        wait_valid8(n, to);
        n_checks++; if (to || z8 !== 16'd156) begin n_fail++; $display("FAIL rmid_fresh got=%h timeout=%0b exp=009c", z8, to); end
        handshake8();
    endtask

    task automatic test_w4_exhaustive();
        int sa, sb;
        logic [7:0] exp_z;
        bit ok;
        for (int m = 0; m < 2; m++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    sa = (m == 1 && ia >= 8) ? ia - 16 : ia;
                    sb = (m == 1 && ib >= 8) ? ib - 16 : ib;
                    exp_z = 8'((sa * sb) & 255);
                    a4 = 4'(ia); b4 = 4'(ib); sm4 = (m == 1); in_valid4 = 1'b1;
                    tick();
                    in_valid4 = 1'b0;
                    ok = 1'b0;
                    for (int t = 0; t < 20; t++) begin
                        if (out_valid4) begin ok = 1'b1; break; end
                        tick();
                    end
                    if (ok) begin
                        ok = 1'b0;
                        for (int t = 0; t < 60; t++) begin
                            out_ready4 = 1'($urandom_range(0, 1));
                            tick();
                            if (out_ready4) begin ok = 1'b1; break; end
                        end
                        out_ready4 = 1'b0;
                    end
                    n_checks++;
                    if (!ok || z4 !== exp_z || out_valid4 !== 1'b0) begin
                        n_fail++;
                        $display("FAIL w4 a=%0d b=%0d sm=%0d got z=%h v=%b done=%0b exp z=%h v=0", ia, ib, m, z4, out_valid4, ok, exp_z);
                    end
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_w4_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
